// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Hazard and resource-sequencing controller for a 5-stage MIPS32
//             pipeline (F/D/E/M/W).
//             - E-stage ALU and D-stage branch-compare forwarding selects
//             - load-use, branch/jr and HI/LO interlocks (stallF/stallD/flushE)
//             - multiplier/divider occupancy sequencer with a HI/LO write pulse
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                 clock, asynchronous active-high reset
//    rsD, rtD                 D-stage source register addresses
//    rsE, rtE                 E-stage source register addresses
//    rf_waE/M/W, we_regE/M/W  destination address / write enable per stage
//    dm_load_opE, dm_load_opM load instruction in E / M
//    branchD, jr_selD         beq / jr in D
//    muldiv_opD, muldiv_opE   mult/div in D / E
//    mul0_div1_selE           0 = mult, 1 = div (qualifies muldiv_opE)
//    hilo_mov_opD             mfhi/mflo in D
//    fwd_aE, fwd_bE           ALU operand select: 00 RF, 01 W result, 10 M alu_out
//    fwd_aD, fwd_bD           branch-compare operand select: 1 = M alu_out
//    stallF, stallD, flushE   hold PC and F/D, bubble into D/E
//    hilo_we                  one-cycle HI/LO register write enable
//    muldiv_busy              sequencer is BUSY
//    stall_cycles             free-running count of cycles with stallD=1
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       rf_waE,
  input  logic [4:0]       rf_waM,
  input  logic [4:0]       rf_waW,
  input  logic             we_regE,
  input  logic             we_regM,
  input  logic             we_regW,
  input  logic             dm_load_opE,
  input  logic             dm_load_opM,
  input  logic             branchD,
  input  logic             jr_selD,
  input  logic             muldiv_opD,
  input  logic             muldiv_opE,
  input  logic             mul0_div1_selE,
  input  logic             hilo_mov_opD,
  output logic [1:0]       fwd_aE,
  output logic [1:0]       fwd_bE,
  output logic             fwd_aD,
  output logic             fwd_bD,
  output logic             stallF,
  output logic             stallD,
  output logic             flushE,
  output logic             hilo_we,
  output logic             muldiv_busy,
  output logic [31:0]      stall_cycles
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // --------------------------------------------------------------------------
  // Address match terms. A destination of $0 never creates a dependency.
  // --------------------------------------------------------------------------
  logic wa_e_nz, wa_m_nz, wa_w_nz;
  assign wa_e_nz = (rf_waE != 5'd0);
  assign wa_m_nz = (rf_waM != 5'd0);
  assign wa_w_nz = (rf_waW != 5'd0);

  logic m_hits_rsE, m_hits_rtE, w_hits_rsE, w_hits_rtE;
  assign m_hits_rsE = we_regM && wa_m_nz && (rf_waM == rsE);
  assign m_hits_rtE = we_regM && wa_m_nz && (rf_waM == rtE);
  assign w_hits_rsE = we_regW && wa_w_nz && (rf_waW == rsE);
  assign w_hits_rtE = we_regW && wa_w_nz && (rf_waW == rtE);

  // E-stage ALU forwarding; the younger M result wins over W.
  always_comb begin
    fwd_aE = 2'b00;
    if (m_hits_rsE)      fwd_aE = 2'b10;
    else if (w_hits_rsE) fwd_aE = 2'b01;
  end

  always_comb begin
    fwd_bE = 2'b00;
    if (m_hits_rtE)      fwd_bE = 2'b10;
    else if (w_hits_rtE) fwd_bE = 2'b01;
  end

  // D-stage compare forwarding: only an ALU result is available in M; a load
  // in M has no data yet and is covered by the branch interlock instead.
  assign fwd_aD = we_regM && !dm_load_opM && wa_m_nz && (rf_waM == rsD);
  assign fwd_bD = we_regM && !dm_load_opM && wa_m_nz && (rf_waM == rtD);

  // --------------------------------------------------------------------------
  // Interlocks
  // --------------------------------------------------------------------------
  logic e_hits_rsD, e_hits_rtD, mld_hits_rsD, mld_hits_rtD;
  assign e_hits_rsD   = we_regE && wa_e_nz && (rf_waE == rsD);
  assign e_hits_rtD   = we_regE && wa_e_nz && (rf_waE == rtD);
  assign mld_hits_rsD = dm_load_opM && wa_m_nz && (rf_waM == rsD);
  assign mld_hits_rtD = dm_load_opM && wa_m_nz && (rf_waM == rtD);

  logic lw_stall, br_stall, md_stall, any_stall;

  assign lw_stall = dm_load_opE && (e_hits_rsD || e_hits_rtD);

  // beq reads rs and rt; jr reads rs only, so its rt field is don't-care.
  assign br_stall = (branchD && (e_hits_rsD || e_hits_rtD || mld_hits_rsD || mld_hits_rtD))
                 || (jr_selD && (e_hits_rsD || mld_hits_rsD));

  // A HI/LO consumer or a second mult/div waits while the unit is occupied,
  // including the cycle in which an op is just issuing from E.
  assign md_stall = (hilo_mov_opD || muldiv_opD) && (muldiv_busy || muldiv_opE);

  assign any_stall = lw_stall || br_stall || md_stall;
  assign stallF    = any_stall;
  assign stallD    = any_stall;
  assign flushE    = any_stall;

  // --------------------------------------------------------------------------
  // Multiply/divide sequencer. The counter holds the number of BUSY cycles
  // remaining after the current one; hilo_we is registered so it is raised on
  // the edge that brings the counter to zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      hilo_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          hilo_we <= 1'b0;
          if (muldiv_opE) begin
            state   <= BUSY;
            cnt     <= mul0_div1_selE ? DIV_LOAD : MUL_LOAD;
            // Single-cycle latency: the first BUSY cycle is already the write.
            hilo_we <= mul0_div1_selE ? (DIV_LAT == 1) : (MUL_LAT == 1);
          end
        end
        BUSY: begin
          // A stray muldiv_opE here is ignored; the running op is not restarted.
          if (cnt == '0) begin
            state   <= IDLE;
            hilo_we <= 1'b0;
          end else begin
            cnt     <= cnt - CNT_ONE;
            hilo_we <= (cnt == CNT_ONE);
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          hilo_we <= 1'b0;
        end
      endcase
    end
  end

  assign muldiv_busy = (state == BUSY);

  // Stall statistics; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'd0;
    end else if (any_stall) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Self-checking bench for pipeline_hazard_ctrl: a table of
//             combinational hazard vectors plus directed multi-cycle sequences
//             for the multiplier/divider sequencer and the stall counter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rsD, rtD, rsE, rtE, rf_waE, rf_waM, rf_waW;
  logic        we_regE, we_regM, we_regW, dm_load_opE, dm_load_opM;
  logic        branchD, jr_selD, muldiv_opD, muldiv_opE, mul0_div1_selE, hilo_mov_opD;
  logic [1:0]  fwd_aE, fwd_bE;
  logic        fwd_aD, fwd_bD, stallF, stallD, flushE, hilo_we, muldiv_busy;
  logic [31:0] stall_cycles;

  pipeline_hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .rf_waE(rf_waE), .rf_waM(rf_waM), .rf_waW(rf_waW),
    .we_regE(we_regE), .we_regM(we_regM), .we_regW(we_regW),
    .dm_load_opE(dm_load_opE), .dm_load_opM(dm_load_opM),
    .branchD(branchD), .jr_selD(jr_selD),
    .muldiv_opD(muldiv_opD), .muldiv_opE(muldiv_opE),
    .mul0_div1_selE(mul0_div1_selE), .hilo_mov_opD(hilo_mov_opD),
    .fwd_aE(fwd_aE), .fwd_bE(fwd_bE), .fwd_aD(fwd_aD), .fwd_bD(fwd_bD),
    .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .hilo_we(hilo_we), .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rsD, rtD, rsE, rtE, waE, waM, waW;
    logic weE, weM, weW, ldE, ldM, br, jr, mdD, mdE, hmD;
  } in_t;

  typedef struct {
    in_t        i;
    logic [1:0] fa, fb;
    logic       fad, fbd, st;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [4:0] T0 = 5'd8, T1 = 5'd9, T2 = 5'd10, T3 = 5'd11, RA = 5'd31;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t v, input logic sel);
    rsD = v.rsD; rtD = v.rtD; rsE = v.rsE; rtE = v.rtE;
    rf_waE = v.waE; rf_waM = v.waM; rf_waW = v.waW;
    we_regE = v.weE; we_regM = v.weM; we_regW = v.weW;
    dm_load_opE = v.ldE; dm_load_opM = v.ldM;
    branchD = v.br; jr_selD = v.jr;
    muldiv_opD = v.mdD; muldiv_opE = v.mdE; hilo_mov_opD = v.hmD;
    mul0_div1_selE = sel;
  endtask

  task automatic add_vec(input in_t v, input logic [1:0] fa, input logic [1:0] fb,
                         input logic fad, input logic fbd, input logic st);
    vec_t r;
    r.i = v; r.fa = fa; r.fb = fb; r.fad = fad; r.fbd = fbd; r.st = st;
    vecs.push_back(r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive('0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_stall(input string name, input logic exp);
    check({name, " stallF"}, {31'd0, stallF}, {31'd0, exp});
    check({name, " stallD"}, {31'd0, stallD}, {31'd0, exp});
    check({name, " flushE"}, {31'd0, flushE}, {31'd0, exp});
  endtask

  initial begin
    in_t v;
    int  pulses;

    // ---------------- vector table ----------------
    v = '0; v.weM = 1; v.waM = T0; v.rsE = T0; v.weW = 1; v.waW = T1; v.rtE = T1;
    add_vec(v, 2'b10, 2'b01, 0, 0, 0);
    v = '0; v.weM = 1; v.waM = 5'd0; v.weW = 1; v.waW = 5'd0;
    add_vec(v, 2'b00, 2'b00, 0, 0, 0);
    v = '0; v.weM = 1; v.waM = T0; v.weW = 1; v.waW = T0; v.rsE = T0; v.rtE = T0;
    add_vec(v, 2'b10, 2'b10, 0, 0, 0);
    v = '0; v.weW = 1; v.waW = T2; v.rsE = T2; v.rtE = T3;
    add_vec(v, 2'b01, 2'b00, 0, 0, 0);
    v = '0; v.ldE = 1; v.weE = 1; v.waE = T0; v.rsD = T0; v.rtD = T2;
    add_vec(v, 2'b00, 2'b00, 0, 0, 1);
    v = '0; v.ldE = 1; v.weE = 1; v.waE = T0; v.rsD = T2; v.rtD = T0;
    add_vec(v, 2'b00, 2'b00, 0, 0, 1);
    v = '0; v.ldE = 1; v.weE = 1; v.waE = 5'd0; v.rsD = 5'd0; v.rtD = 5'd0;
    add_vec(v, 2'b00, 2'b00, 0, 0, 0);
    v = '0; v.weE = 1; v.waE = T0; v.br = 1; v.rsD = T0; v.rtD = T3;
    add_vec(v, 2'b00, 2'b00, 0, 0, 1);
    v = '0; v.weE = 1; v.waE = T0; v.jr = 1; v.rsD = RA; v.rtD = T0;
    add_vec(v, 2'b00, 2'b00, 0, 0, 0);
    v = '0; v.weE = 1; v.waE = T0; v.jr = 1; v.rsD = T0;
    add_vec(v, 2'b00, 2'b00, 0, 0, 1);
    v = '0; v.weM = 1; v.waM = T0; v.br = 1; v.rsD = T0; v.rtD = T3;
    add_vec(v, 2'b00, 2'b00, 1, 0, 0);
    v = '0; v.weM = 1; v.waM = T1; v.rsD = 5'd0; v.rtD = T1;
    add_vec(v, 2'b00, 2'b00, 0, 1, 0);
    v = '0; v.weM = 1; v.ldM = 1; v.waM = T0; v.br = 1; v.rsD = T0;
    add_vec(v, 2'b00, 2'b00, 0, 0, 1);
    v = '0; v.weM = 1; v.ldM = 1; v.waM = T3; v.br = 1; v.rsD = T2; v.rtD = T3;
    add_vec(v, 2'b00, 2'b00, 0, 0, 1);
    v = '0; v.weM = 1; v.ldM = 1; v.waM = T3; v.jr = 1; v.rsD = T2; v.rtD = T3;
    add_vec(v, 2'b00, 2'b00, 0, 0, 0);
    v = '0; v.mdD = 1;
    add_vec(v, 2'b00, 2'b00, 0, 0, 0);
    v = '0; v.hmD = 1; v.mdE = 1;  // last: starts the sequencer
    add_vec(v, 2'b00, 2'b00, 0, 0, 1);

    drive('0, 1'b0);
    rst = 1'b1;
    #1;
    check("reset busy", {31'd0, muldiv_busy}, 32'd0);
    check("reset hilo_we", {31'd0, hilo_we}, 32'd0);
    check("reset stall_cycles", stall_cycles, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].i, 1'b0);
      #1;
      check($sformatf("vec%0d fwd_aE", k), {30'd0, fwd_aE}, {30'd0, vecs[k].fa});
      check($sformatf("vec%0d fwd_bE", k), {30'd0, fwd_bE}, {30'd0, vecs[k].fb});
      check($sformatf("vec%0d fwd_aD", k), {31'd0, fwd_aD}, {31'd0, vecs[k].fad});
      check($sformatf("vec%0d fwd_bD", k), {31'd0, fwd_bD}, {31'd0, vecs[k].fbd});
      check_stall($sformatf("vec%0d", k), vecs[k].st);
    end

    // ---------------- load-use sequence ----------------
    do_reset();
    v = '0; v.ldE = 1; v.weE = 1; v.waE = T0; v.rsD = T0; v.rtD = T2;
    drive(v, 1'b0); #1;
    check_stall("lw c1", 1'b1);
    @(negedge clk);
    v = '0; v.ldM = 1; v.weM = 1; v.waM = T0; v.rsD = T0; v.rtD = T2;
    drive(v, 1'b0); #1;
    check_stall("lw c2", 1'b0);
    check("lw stall_cycles", stall_cycles, 32'd1);
    @(negedge clk);
    v = '0; v.weW = 1; v.waW = T0; v.rsE = T0; v.rtE = T2;
    drive(v, 1'b0); #1;
    check("lw fwd_aE", {30'd0, fwd_aE}, 32'd1);
    check("lw stall_cycles end", stall_cycles, 32'd1);

    // ---------------- branch sequence ----------------
    @(negedge clk);
    v = '0; v.weE = 1; v.waE = T0; v.br = 1; v.rsD = T0; v.rtD = T3;
    drive(v, 1'b0); #1;
    check_stall("br c1", 1'b1);
    @(negedge clk);
    v = '0; v.weM = 1; v.waM = T0; v.br = 1; v.rsD = T0; v.rtD = T3;
    drive(v, 1'b0); #1;
    check_stall("br c2", 1'b0);
    check("br fwd_aD", {31'd0, fwd_aD}, 32'd1);

    // ---------------- mult then mflo ----------------
    do_reset();
    v = '0; v.mdE = 1;
    drive(v, 1'b0); #1;
    check("mul c0 busy", {31'd0, muldiv_busy}, 32'd0);
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      v = '0; v.hmD = 1;
      drive(v, 1'b0); #1;
      check($sformatf("mul c%0d busy", t), {31'd0, muldiv_busy}, {31'd0, (t <= 4)});
      check($sformatf("mul c%0d hilo_we", t), {31'd0, hilo_we}, {31'd0, (t == 4)});
      check($sformatf("mul c%0d stallD", t), {31'd0, stallD}, {31'd0, (t <= 4)});
    end

    // ---------------- div then mult back to back ----------------
    do_reset();
    for (int t = 0; t <= 40; t++) begin
      if (t > 0) @(negedge clk);
      v = '0;
      if (t == 0) begin v.mdE = 1; v.mdD = 1; drive(v, 1'b1); end
      else if (t <= 33) begin v.mdD = 1; drive(v, 1'b0); end
      else if (t == 34) begin v.mdE = 1; drive(v, 1'b0); end
      else drive(v, 1'b0);
      #1;
      check($sformatf("dm c%0d stallD", t), {31'd0, stallD}, {31'd0, (t <= 32)});
      check($sformatf("dm c%0d hilo_we", t), {31'd0, hilo_we}, {31'd0, (t == 32 || t == 38)});
      check($sformatf("dm c%0d busy", t), {31'd0, muldiv_busy},
            {31'd0, ((t >= 1 && t <= 32) || (t >= 35 && t <= 38))});
    end
    check("dm stall_cycles", stall_cycles, 32'd33);

    // ---------------- reset during BUSY ----------------
    do_reset();
    v = '0; v.mdE = 1;
    drive(v, 1'b1);
    for (int t = 1; t <= 27; t++) begin
      @(negedge clk);
      v = '0; v.mdD = 1;
      drive(v, 1'b0);
    end
    #1;
    check("abort pre busy", {31'd0, muldiv_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort busy", {31'd0, muldiv_busy}, 32'd0);
    check("abort hilo_we", {31'd0, hilo_we}, 32'd0);
    check("abort stall_cycles", stall_cycles, 32'd0);
    @(negedge clk);
    drive('0, 1'b0);
    rst = 1'b0;
    pulses = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk); #1;
      if (hilo_we) pulses++;
    end
    check("abort hilo_we pulses", pulses, 32'd0);
    check("abort busy after", {31'd0, muldiv_busy}, 32'd0);

    // ---------------- stall counter wrap ----------------
    @(negedge clk);
    force dut.stall_cycles = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cycles;
    v = '0; v.ldE = 1; v.weE = 1; v.waE = T0; v.rsD = T0;
    drive(v, 1'b0);
    @(negedge clk);
    drive('0, 1'b0);
    #1;
    check("wrap stall_cycles", stall_cycles, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
